// File: rtl/mem_lsu.sv
// Memory-access stage: registers the EX/MEM boundary, runs loads/stores over a req/ack bus,
// formats load data and store lanes, and stalls upstream while a bus access is outstanding.
module mem_lsu #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic        rd_wen_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [2:0]  mem_size_i,
  input  logic        mem_we_i,
  input  logic        mem_re_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_wen_o,
  output logic        mem_re_o,
  output logic        hold_flag_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  localparam logic             TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [31:0]       bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_wen_q, rd_wen_d, mem_re_q, mem_re_d;
  logic              misalign_q, misalign_d, bus_err_q, bus_err_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        lo_q, lo_d;
  logic              ld_q, ld_d, ld_wen_q, ld_wen_d;
  logic [4:0]        ld_rd_q, ld_rd_d;
  logic              pend_vld_q, pend_vld_d;
  logic [4:0]        pend_addr_q, pend_addr_d;
  logic [31:0]       pend_data_q, pend_data_d;
  logic              hold, accept, retire_ld;

  function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] lo);
    case (size[1:0])
      2'b00:   return 1'b1;
      2'b01:   return ~lo[0];
      default: return (lo == 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] st_wdata(input logic [2:0] size, input logic [31:0] d);
    case (size[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] st_be(input logic [2:0] size, input logic [1:0] lo);
    case (size[1:0])
      2'b00:   return 4'(4'b0001 << lo);
      2'b01:   return 4'(4'b0011 << lo);
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input logic [2:0] size,
                                           input logic [1:0] lo);
    logic [31:0] b;
    b = rdata >> {lo, 3'b000};
    case (size)
      3'b000:  return {{24{b[7]}}, b[7:0]};
      3'b100:  return {24'b0, b[7:0]};
      3'b001:  return {{16{b[15]}}, b[15:0]};
      3'b101:  return {16'b0, b[15:0]};
      default: return rdata;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    rd_wen_d    = 1'b0;
    mem_re_d    = 1'b0;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    size_d      = size_q;
    lo_d        = lo_q;
    ld_d        = ld_q;
    ld_rd_d     = ld_rd_q;
    ld_wen_d    = ld_wen_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    hold        = 1'b0;
    accept      = 1'b0;
    retire_ld   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // An ALU result accepted in a load's ack cycle retires one cycle late.
        if (pend_vld_q) begin
          rd_addr_d  = pend_addr_q;
          rd_data_d  = pend_data_q;
          rd_wen_d   = 1'b1;
          pend_vld_d = 1'b0;
          hold       = 1'b1;
        end else begin
          accept = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus_ack_i) begin
          bus_req_d = 1'b0;
          state_d   = S_IDLE;
          cnt_d     = '0;
          accept    = 1'b1;
          if (ld_q) begin
            retire_ld = 1'b1;
            rd_addr_d = ld_rd_q;
            rd_data_d = fmt_load(bus_rdata_i, size_q, lo_q);
            rd_wen_d  = ld_wen_q;
            mem_re_d  = 1'b1;
          end
        end else if (TO_EN && cnt_q == TO_LAST) begin
          bus_req_d = 1'b0;
          state_d   = S_IDLE;
          cnt_d     = '0;
          bus_err_d = 1'b1;
          hold      = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          hold  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      if (mem_we_i || mem_re_i) begin
        if (!is_aligned(mem_size_i, mem_addr_i[1:0])) begin
          misalign_d = 1'b1;
        end else begin
          state_d     = S_WAIT;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_addr_d  = {mem_addr_i[31:2], 2'b00};
          bus_wdata_d = st_wdata(mem_size_i, mem_data_i);
          bus_be_d    = mem_we_i ? st_be(mem_size_i, mem_addr_i[1:0]) : 4'b1111;
          size_d      = mem_size_i;
          lo_d        = mem_addr_i[1:0];
          ld_d        = ~mem_we_i;
          ld_rd_d     = rd_addr_i;
          ld_wen_d    = rd_wen_i;
        end
      end else if (retire_ld) begin
        if (rd_wen_i) begin
          pend_vld_d  = 1'b1;
          pend_addr_d = rd_addr_i;
          pend_data_d = rd_data_i;
        end
      end else begin
        rd_addr_d = rd_addr_i;
        rd_data_d = rd_data_i;
        rd_wen_d  = rd_wen_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      rd_wen_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      ld_q        <= 1'b0;
      pend_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      rd_wen_q    <= rd_wen_d;
      mem_re_q    <= mem_re_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
      ld_q        <= ld_d;
      pend_vld_q  <= pend_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    size_q      <= size_d;
    lo_q        <= lo_d;
    ld_rd_q     <= ld_rd_d;
    ld_wen_q    <= ld_wen_d;
    pend_addr_q <= pend_addr_d;
    pend_data_q <= pend_data_d;
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_be_o    = bus_be_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_data_o   = rd_data_q;
  assign rd_wen_o    = rd_wen_q;
  assign mem_re_o    = mem_re_q;
  assign hold_flag_o = hold;
  assign misalign_o  = misalign_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: retirements are checked against a scoreboard queue,
// bus-side behaviour against directly computed expectations.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic        rd_wen_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [2:0]  mem_size_i;
  logic        mem_we_i;
  logic        mem_re_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_wen_o;
  logic        mem_re_o;
  logic        hold_flag_o;
  logic        misalign_o;
  logic        bus_err_o;

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .rd_wen_i(rd_wen_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_size_i(mem_size_i),
    .mem_we_i(mem_we_i), .mem_re_i(mem_re_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wen_o(rd_wen_o),
    .mem_re_o(mem_re_o), .hold_flag_o(hold_flag_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic        ld;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Every retirement seen on rd_wen_o must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && rd_wen_o) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_retire", 32'(rd_wen_o), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_rd_addr", 32'(rd_addr_o), 32'(e.a));
        check("sb_rd_data", rd_data_o, e.d);
        check("sb_mem_re", 32'(mem_re_o), 32'(e.ld));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic drive(input logic [4:0] rd, input logic [31:0] rdata, input logic wen,
                       input logic [31:0] addr, input logic [31:0] data, input logic [2:0] size,
                       input logic we, input logic re);
    rd_addr_i  = rd;
    rd_data_i  = rdata;
    rd_wen_i   = wen;
    mem_addr_i = addr;
    mem_data_i = data;
    mem_size_i = size;
    mem_we_i   = we;
    mem_re_i   = re;
  endtask

  task automatic nop();
    drive(5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] size, input logic [4:0] rd,
                         input logic [31:0] rdata, input int n, input logic [31:0] expd);
    exp_t e;
    drive(rd, 32'h0, 1'b1, addr, 32'h0, size, 1'b0, 1'b1);
    at_neg();
    check("ld_idle_hold", 32'(hold_flag_o), 32'd0);
    step();
    nop();
    for (int k = 1; k <= n; k++) begin
      if (k == n) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = rdata;
        e = '{a: rd, d: expd, ld: 1'b1};
        sb_q.push_back(e);
      end
      at_neg();
      check("ld_req", 32'(bus_req_o), 32'd1);
      check("ld_addr", bus_addr_o, {addr[31:2], 2'b00});
      check("ld_be", 32'(bus_be_o), 32'hF);
      check("ld_we", 32'(bus_we_o), 32'd0);
      check("ld_hold", 32'(hold_flag_o), 32'(k < n));
      step();
    end
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;
    at_neg();
    check("ld_req_drop", 32'(bus_req_o), 32'd0);
    check("ld_no_err", 32'(bus_err_o), 32'd0);
    step();
    check("ld_sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata, input int n);
    drive(5'd9, 32'h0, 1'b1, addr, data, size, 1'b1, 1'b0);
    step();
    nop();
    for (int k = 1; k <= n; k++) begin
      if (k == n) bus_ack_i = 1'b1;
      at_neg();
      check("st_req", 32'(bus_req_o), 32'd1);
      check("st_we", 32'(bus_we_o), 32'd1);
      check("st_addr", bus_addr_o, {addr[31:2], 2'b00});
      check("st_be", 32'(bus_be_o), 32'(exp_be));
      check("st_wdata", bus_wdata_o, exp_wdata);
      check("st_hold", 32'(hold_flag_o), 32'(k < n));
      step();
    end
    bus_ack_i = 1'b0;
    at_neg();
    check("st_req_drop", 32'(bus_req_o), 32'd0);
    check("st_no_wen", 32'(rd_wen_o), 32'd0);
    step();
  endtask

  task automatic do_misalign(input logic [31:0] addr, input logic [2:0] size,
                             input logic we, input logic re);
    drive(5'd11, 32'h0, 1'b1, addr, 32'h5A5A_5A5A, size, we, re);
    at_neg();
    check("mis_hold", 32'(hold_flag_o), 32'd0);
    step();
    nop();
    at_neg();
    check("mis_pulse", 32'(misalign_o), 32'd1);
    check("mis_no_req", 32'(bus_req_o), 32'd0);
    check("mis_no_wen", 32'(rd_wen_o), 32'd0);
    step();
    at_neg();
    check("mis_pulse_end", 32'(misalign_o), 32'd0);
    check("mis_still_no_req", 32'(bus_req_o), 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    nop();
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;
    rst         = 1'b1;
    step();
    step();
    at_neg();
    check("rst_req", 32'(bus_req_o), 32'd0);
    check("rst_be", 32'(bus_be_o), 32'd0);
    check("rst_wen", 32'(rd_wen_o), 32'd0);
    check("rst_data", rd_data_o, 32'd0);
    check("rst_mem_re", 32'(mem_re_o), 32'd0);
    check("rst_hold", 32'(hold_flag_o), 32'd0);
    check("rst_misalign", 32'(misalign_o), 32'd0);
    check("rst_err", 32'(bus_err_o), 32'd0);
    step();
    rst = 1'b0;

    // Reset while a load is waiting, then a late ack.
    drive(5'd7, 32'h0, 1'b1, 32'h100, 32'h0, 3'b010, 1'b0, 1'b1);
    step();
    nop();
    at_neg();
    check("wait_req", 32'(bus_req_o), 32'd1);
    check("wait_hold", 32'(hold_flag_o), 32'd1);
    step();
    rst = 1'b1;
    step();
    step();
    at_neg();
    check("rstw_req", 32'(bus_req_o), 32'd0);
    check("rstw_hold", 32'(hold_flag_o), 32'd0);
    check("rstw_be", 32'(bus_be_o), 32'd0);
    check("rstw_addr", bus_addr_o, 32'd0);
    check("rstw_wen", 32'(rd_wen_o), 32'd0);
    step();
    rst         = 1'b0;
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'hFFFF_FFFF;
    at_neg();
    check("late_ack_hold", 32'(hold_flag_o), 32'd0);
    step();
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;
    at_neg();
    check("late_ack_req", 32'(bus_req_o), 32'd0);
    check("late_ack_wen", 32'(rd_wen_o), 32'd0);
    check("late_ack_mem_re", 32'(mem_re_o), 32'd0);
    step();

    // Plain ALU result passes through with one cycle of latency.
    drive(5'd5, 32'h0000_1234, 1'b1, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    e = '{a: 5'd5, d: 32'h0000_1234, ld: 1'b0};
    sb_q.push_back(e);
    at_neg();
    check("alu_hold", 32'(hold_flag_o), 32'd0);
    step();
    nop();
    at_neg();
    check("alu_wen", 32'(rd_wen_o), 32'd1);
    step();
    check("alu_sb_drained", 32'(sb_q.size()), 32'd0);

    // Load formatting by size and sign.
    do_load(32'h103, 3'b000, 5'd6, 32'h80FF_0000, 3, 32'hFFFF_FF80);
    do_load(32'h103, 3'b100, 5'd6, 32'h80FF_0000, 3, 32'h0000_0080);
    do_load(32'h102, 3'b001, 5'd8, 32'h80FF_0000, 1, 32'hFFFF_80FF);
    do_load(32'h100, 3'b101, 5'd8, 32'h1234_8765, 2, 32'h0000_8765);
    do_load(32'h104, 3'b010, 5'd10, 32'hA5A5_0F0F, 1, 32'hA5A5_0F0F);

    // Store lane formatting.
    do_store(32'h202, 3'b001, 32'hABCD_1234, 4'b1100, 32'h1234_1234, 2);
    do_store(32'h201, 3'b000, 32'h0000_0055, 4'b0010, 32'h5555_5555, 1);
    do_store(32'h208, 3'b010, 32'hCAFE_BABE, 4'b1111, 32'hCAFE_BABE, 1);

    // Misaligned accesses never reach the bus.
    do_misalign(32'h102, 3'b010, 1'b0, 1'b1);
    do_misalign(32'h201, 3'b001, 1'b1, 1'b0);

    // Timeout with no ack.
    drive(5'd12, 32'h0, 1'b1, 32'h300, 32'h0, 3'b010, 1'b0, 1'b1);
    step();
    nop();
    for (int k = 1; k <= 16; k++) begin
      at_neg();
      check("to_req", 32'(bus_req_o), 32'd1);
      check("to_hold", 32'(hold_flag_o), 32'd1);
      check("to_err_early", 32'(bus_err_o), 32'd0);
      step();
    end
    at_neg();
    check("to_err", 32'(bus_err_o), 32'd1);
    check("to_req_drop", 32'(bus_req_o), 32'd0);
    check("to_hold_rel", 32'(hold_flag_o), 32'd0);
    check("to_wen", 32'(rd_wen_o), 32'd0);
    step();
    at_neg();
    check("to_err_end", 32'(bus_err_o), 32'd0);
    step();

    // Ack in the last allowed cycle wins over the timeout.
    do_load(32'h300, 3'b010, 5'd12, 32'h1357_2468, 16, 32'h1357_2468);

    // Back-to-back: a store presented in the load's ack cycle starts immediately.
    drive(5'd13, 32'h0, 1'b1, 32'h400, 32'h0, 3'b010, 1'b0, 1'b1);
    step();
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'hDEAD_BEEF;
    e = '{a: 5'd13, d: 32'hDEAD_BEEF, ld: 1'b1};
    sb_q.push_back(e);
    drive(5'd0, 32'h0, 1'b0, 32'h404, 32'hCAFE_F00D, 3'b010, 1'b1, 1'b0);
    at_neg();
    check("b2b_ack_hold", 32'(hold_flag_o), 32'd0);
    step();
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;
    nop();
    at_neg();
    check("b2b_req", 32'(bus_req_o), 32'd1);
    check("b2b_we", 32'(bus_we_o), 32'd1);
    check("b2b_addr", bus_addr_o, 32'h404);
    check("b2b_wdata", bus_wdata_o, 32'hCAFE_F00D);
    step();
    bus_ack_i = 1'b1;
    at_neg();
    check("b2b_st_ack_hold", 32'(hold_flag_o), 32'd0);
    step();
    bus_ack_i = 1'b0;
    at_neg();
    check("b2b_req_drop", 32'(bus_req_o), 32'd0);
    step();
    check("final_sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-access stage directly downstream of the execute stage.
- Registers the execute results (the EX/MEM boundary) and performs loads and stores on the data bus through a req/ack handshake.
- Formats load data by size and sign, and generates byte-lane strobes for stores.
- Stalls the upstream pipeline while a bus transaction is outstanding, and reports misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: number of WAIT cycles without ack before the access is aborted; 0 disables the timeout.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr_i  in  5  destination register from execute.
- rd_data_i  in  32  ALU result from execute.
- rd_wen_i  in  1  register write enable from execute.
- mem_addr_i  in  32  byte address of the access.
- mem_data_i  in  32  store data (low bits significant).
- mem_size_i  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_we_i  in  1  store request.
- mem_re_i  in  1  load request.
- bus_req_o  out  1  bus request, held high until ack.
- bus_we_o  out  1  1 = write.
- bus_addr_o  out  32  word-aligned address, {mem_addr[31:2], 2'b00}.
- bus_wdata_o  out  32  lane-replicated store data.
- bus_be_o  out  4  byte-lane enables.
- bus_rdata_i  in  32  read data, valid in the cycle bus_ack_i is high.
- bus_ack_i  in  1  transaction complete.
- rd_addr_o  out  5  to mem_wb.
- rd_data_o  out  32  to mem_wb.
- rd_wen_o  out  1  to mem_wb.
- mem_re_o  out  1  registered: the retiring instruction was a load (for forwarding muxes).
- hold_flag_o  out  1  to control: freeze PC, IF/ID, ID/EX.
- misalign_o  out  1  one-cycle pulse on a misaligned access.
- bus_err_o  out  1  one-cycle pulse on a timeout abort.

Behaviour:
- Reset: state IDLE.
  - All outputs 0, including bus_req_o, bus_be_o, rd_wen_o and the pulses.
  - Timeout counter cleared.
  - Reset asserted during WAIT drops bus_req_o at that edge; a late ack is ignored.
- States: IDLE, WAIT.
- IDLE, non-memory instruction (mem_we_i = mem_re_i = 0):
  - Register rd_* at the edge; 1-cycle latency.
  - mem_re_o = 0; hold_flag_o = 0.
- IDLE, memory instruction:
  - Check alignment: H/HU needs addr[0] = 0; W needs addr[1:0] = 0; B/BU are always aligned.
  - Misaligned:
    - Stay IDLE, no bus cycle, store suppressed.
    - Next cycle: misalign_o = 1 and rd_wen_o = 0.
  - Aligned:
    - At the edge: latch address, size, rd_addr and the load flag; drive bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o; set bus_req_o = 1; go to WAIT; rd_wen_o = 0 (bubble).
  - If mem_we_i and mem_re_i are both 1, the store takes priority.
- Store formatting:
  - SB: wdata = {4{data[7:0]}}, be = 4'b0001 << addr[1:0].
  - SH: wdata = {2{data[15:0]}}, be = 4'b0011 << addr[1:0].
  - SW: wdata = data, be = 4'b1111.
  - Loads: be = 4'b1111.
- WAIT:
  - hold_flag_o = ~bus_ack_i (combinational), so the next instruction waits at the execute outputs.
  - Counter increments each cycle without ack.
  - On ack: at that edge bus_req_o = 0, state IDLE.
    - Load: rd_data_o is the formatted load value, rd_wen_o = rd_wen latched, mem_re_o = 1.
    - Store: rd_wen_o = 0.
    - The instruction presented upstream in the ack cycle is captured in the same edge (back-to-back accesses have no dead cycle: an aligned memory op re-enters WAIT immediately).
- Load formatting:
  - sh = addr[1:0] * 8; b = rdata >> sh.
  - B: sign-extend b[7:0]. BU: zero-extend b[7:0].
  - H: sign-extend b[15:0]. HU: zero-extend b[15:0].
  - W: rdata.
  - Unlisted size codes are treated as W.
- Timeout (TIMEOUT_CYCLES > 0): if the counter reaches TIMEOUT_CYCLES without ack:
  - Drop bus_req_o, go to IDLE.
  - bus_err_o pulses for 1 cycle; rd_wen_o = 0.
  - hold_flag_o releases in that cycle.
- Ack arriving in the same cycle as the timeout: ack wins; no error.
- bus_* outputs other than bus_req_o hold stable throughout WAIT.

Test Plan:
- Reset with rst = 1 for 2 cycles during WAIT -> bus_req_o = 0, all outputs 0, state IDLE; a subsequent ack has no effect.
- ADD result rd = 5, data 0x1234 -> rd_wen_o = 1, rd_addr_o = 5, rd_data_o = 0x1234 one cycle later; hold_flag_o never asserted.
- LB at addr 0x103, ack after 3 WAIT cycles with rdata 0x80FF_0000 -> bus_addr_o = 0x100, hold_flag_o high for 2 cycles then low in the ack cycle, rd_data_o = 0xFFFF_FF80; LBU on the same data gives 0x0000_0080, mem_re_o = 1.
- SH at addr 0x202 with data 0xABCD_1234 -> bus_be_o = 4'b1100, bus_wdata_o = 0x1234_1234, bus_we_o = 1, rd_wen_o = 0; SB at 0x201 -> be = 4'b0010.
- LW at addr 0x102 -> no bus_req_o, misalign_o pulses once, rd_wen_o = 0; SH at 0x201 -> same, with no write.
- LW with no ack, TIMEOUT_CYCLES = 16 -> bus_err_o pulses after 16 WAIT cycles, bus_req_o drops, hold_flag_o releases; repeat with ack in the 16th cycle -> data retired, no error.
